// File: rtl/bconv3x3_stream.sv
// rtl/bconv3x3_stream.sv - streaming 3x3 binary (XNOR-popcount) convolution
// over a 1-bit raster image, one registered output stage with full backpressure.
module bconv3x3_stream #(
   parameter int                         WIDTH    = 28,
   parameter int                         HEIGHT   = 28,
   parameter int                         CH_OUT   = 8,
   parameter logic [CH_OUT*9-1:0]        WEIGHTS  = '1,
   parameter int                         THRESH_W = 4,
   parameter logic [CH_OUT*THRESH_W-1:0] THRESH   = {CH_OUT{THRESH_W'(5)}}
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_pixel,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH_OUT-1:0]          out_data,
   output logic [$clog2(HEIGHT)-1:0]  out_row,
   output logic [$clog2(WIDTH)-1:0]   out_col,
   output logic                       frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   logic [CW-1:0]     col_in;
   logic [RW-1:0]     row_in;
   logic [WIDTH-1:0]  lb_top;   // pixels of row_in-2, indexed by column
   logic [WIDTH-1:0]  lb_mid;   // pixels of row_in-1, indexed by column
   logic [8:0]        win;
   logic [8:0]        win_nxt;
   logic [3:0]        pop [CH_OUT];
   logic [CH_OUT-1:0] res;
   logic              accept;
   logic              win_full;
   logic              last_out;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign win_full = (row_in >= RW'(2)) && (col_in >= CW'(2));
   assign last_out = (out_row == RW'(HEIGHT-3)) && (out_col == CW'(WIDTH-3));

   // Each window row shifts toward the older column; the new column enters at taps 2/5/8.
   assign win_nxt = {in_pixel, win[8:7], lb_mid[col_in], win[5:4], lb_top[col_in], win[2:1]};

   always_comb begin
      for (int c = 0; c < CH_OUT; c++) begin
         pop[c] = '0;
         for (int k = 0; k < 9; k++) begin
            pop[c] = pop[c] + {3'b000, ~(win_nxt[k] ^ WEIGHTS[c*9+k])};
         end
         res[c] = THRESH_W'(pop[c]) >= THRESH[c*THRESH_W +: THRESH_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_in     <= '0;
         row_in     <= '0;
         lb_top     <= '0;
         lb_mid     <= '0;
         win        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_valid && out_ready && last_out;
         if (accept) begin
            win            <= win_nxt;
            lb_top[col_in] <= lb_mid[col_in];
            lb_mid[col_in] <= in_pixel;
            if (col_in == CW'(WIDTH-1)) begin
               col_in <= '0;
               row_in <= (row_in == RW'(HEIGHT-1)) ? '0 : row_in + RW'(1);
            end else begin
               col_in <= col_in + CW'(1);
            end
         end
         if (accept && win_full) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_row   <= row_in - RW'(2);
            out_col   <= col_in - CW'(2);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bconv3x3_stream.sv
// tb/tb_bconv3x3_stream.sv - directed bench: default 28x28 stream with scoreboard,
// plus a 5x4 four-channel instance with hand-computed results.
module tb_bconv3x3_stream;

   localparam int W = 28;
   localparam int H = 28;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_pixel = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, frame_done;
   logic [7:0] out_data;
   logic [4:0] out_row, out_col;

   logic       s_in_valid = 1'b0, s_in_pixel = 1'b0, s_out_ready = 1'b1;
   logic       s_in_ready, s_out_valid, s_frame_done;
   logic [3:0] s_out_data;
   logic [1:0] s_out_row;
   logic [2:0] s_out_col;

   always #5 clk = ~clk;

   bconv3x3_stream dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
   );

   bconv3x3_stream #(
      .WIDTH(5), .HEIGHT(4), .CH_OUT(4),
      .WEIGHTS({9'h1FF, 9'h1FF, 9'h000, 9'h1FF}),
      .THRESH_W(4),
      .THRESH({4'd10, 4'd0, 4'd9, 4'd9})
   ) sdut (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_row(s_out_row), .out_col(s_out_col), .frame_done(s_frame_done)
   );

   typedef struct {logic [7:0] d; int r; int c;} exp_t;

   int   n_assert = 0, n_fail = 0;
   exp_t sb[$];
   int   br = 0, bc = 0, fi = 0, acc_cnt = 0, n_out = 0, n_fd = 0;
   int   kinds[2];
   bit   rnd_img [H][W];
   bit   exp_fd = 1'b0, prev_stall = 1'b0;
   logic [7:0] pd;
   logic [4:0] pr, pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pix(input int k, input int r, input int c);
      case (k)
         0:       return 1'b1;
         1:       return ((r + c) % 2) == 0;
         2:       return ((r + c) % 2) == 1;
         default: return rnd_img[r][c];
      endcase
   endfunction

   // Default weights are all ones, so the popcount is just the number of set pixels.
   function automatic logic [7:0] model(input int k, input int r, input int c);
      int p = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p += int'(pix(k, r + i, c + j));
      return (p >= 5) ? 8'hFF : 8'h00;
   endfunction

   task automatic step(input bit iv, input bit ordy);
      exp_t e;
      bit   hs;
      in_valid  = iv;
      out_ready = ordy;
      in_pixel  = iv ? pix(kinds[fi % 2], br, bc) : 1'b0;
      #1;
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) n_fd++;
      chk("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
      if (prev_stall) begin
         chk("hold_data", 32'(out_data), 32'(pd));
         chk("hold_row", 32'(out_row), 32'(pr));
         chk("hold_col", 32'(out_col), 32'(pc));
      end
      hs     = out_valid && ordy;
      exp_fd = 1'b0;
      if (hs) begin
         n_out++;
         chk("unexpected_output", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_row", 32'(out_row), 32'(e.r));
            chk("out_col", 32'(out_col), 32'(e.c));
            exp_fd = (e.r == H - 3) && (e.c == W - 3);
         end
      end
      prev_stall = out_valid && !ordy;
      pd = out_data; pr = out_row; pc = out_col;
      if (iv && in_ready) begin
         if (br >= 2 && bc >= 2) sb.push_back('{model(kinds[fi % 2], br - 2, bc - 2), br - 2, bc - 2});
         acc_cnt++;
         if (bc == W - 1) begin
            bc = 0;
            if (br == H - 1) begin br = 0; fi++; end
            else br++;
         end else bc++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int npix, input bit rv, input bit rr);
      int target = acc_cnt + npix;
      int guard = 0;
      while (acc_cnt < target && guard < 20000) begin
         step(rv ? 1'($urandom_range(0, 1)) : 1'b1, rr ? 1'($urandom_range(0, 1)) : 1'b1);
         guard++;
      end
      chk("feed_timeout", 32'(guard < 20000), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      chk("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic new_run(input int k0, input int k1);
      kinds[0] = k0; kinds[1] = k1;
      fi = 0; n_out = 0; n_fd = 0;
   endtask

   initial begin
      logic [3:0] sexp [6];
      int pi, so, sfd;
      sexp = '{4'h4, 4'h4, 4'h6, 4'h4, 4'h4, 4'h6};
      kinds[0] = 0; kinds[1] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_row", 32'(out_row), 32'd0);
      chk("rst_out_col", 32'(out_col), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // all-ones frame, continuous flow
      new_run(0, 0);
      run(W * H, 1'b0, 1'b0);
      chk("ones_count", 32'(n_out), 32'd676);
      chk("ones_fd", 32'(n_fd), 32'd1);

      // checkerboard then inverted checkerboard, back to back
      new_run(1, 2);
      run(2 * W * H, 1'b0, 1'b0);
      chk("b2b_count", 32'(n_out), 32'd1352);
      chk("b2b_fd", 32'(n_fd), 32'd2);

      // random image with random input gaps and output backpressure
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            rnd_img[r][c] = 1'($urandom_range(0, 1));
      new_run(3, 3);
      run(W * H, 1'b1, 1'b1);
      chk("bp_count", 32'(n_out), 32'd676);
      chk("bp_fd", 32'(n_fd), 32'd1);

      // small instance: single set pixel at (1,1), two frames
      pi = 0; so = 0; sfd = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         s_in_valid = (pi < 40);
         s_in_pixel = (pi % 20) == 6;
         #1;
         if (s_out_valid) begin
            if (so < 12) begin
               chk("s_data", 32'(s_out_data), 32'(sexp[so % 6]));
               chk("s_row", 32'(s_out_row), 32'((so % 6) / 3));
               chk("s_col", 32'(s_out_col), 32'((so % 6) % 3));
            end
            so++;
         end
         if (s_frame_done) sfd++;
         if (s_in_valid && s_in_ready) pi++;
         @(posedge clk);
         @(negedge clk);
      end
      s_in_valid = 1'b0;
      chk("s_count", 32'(so), 32'd12);
      chk("s_fd", 32'(sfd), 32'd2);

      // reset mid-frame while an output is stalled
      new_run(0, 0);
      while (acc_cnt % (W * H) != 300) step(1'b1, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", 32'(out_data), 32'd0);
      sb.delete();
      br = 0; bc = 0; acc_cnt = 0;
      prev_stall = 1'b0; exp_fd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      new_run(0, 0);
      run(W * H, 1'b0, 1'b0);
      chk("post_rst_count", 32'(n_out), 32'd676);
      chk("post_rst_fd", 32'(n_fd), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bconv3x3_stream.md
Name: bconv3x3_stream

Overview:
- Parametrised streaming 3x3 binary convolution layer with valid/ready handshakes on both sides.
- Consumes a 1-bit raster-scan image one pixel per handshake and produces CH_OUT 1-bit feature bits per output position.
- Uses XNOR-popcount against packed weights, then a per-channel threshold.
- Generalises the fixed 28x28, 8-channel first conv stage: any image size, any channel count, programmable thresholds, full backpressure, output coordinates, frame-done marker.

Parameters:
- WIDTH, 28: image columns, must be ≥3.
- HEIGHT, 28: image rows, must be ≥3.
- CH_OUT, 8: output channels, must be ≥1.
- WEIGHTS, all ones (CH_OUT*9 bits): weight for channel c, tap k at bit c*9+k. Taps are row-major over the window, k=0 is top-left (oldest row, oldest column), k=8 is bottom-right (current pixel).
- THRESH_W, 4: threshold field width, must be ≥4.
- THRESH, every field 5 (CH_OUT*THRESH_W bits): threshold for channel c at bits [c*THRESH_W +: THRESH_W].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  1  raster pixel
- out_valid  out  1  out_data, out_row and out_col are valid
- out_ready  in  1  downstream accepts the output
- out_data  out  CH_OUT  bit c is the channel c result
- out_row  out  $clog2(HEIGHT)  output row, 0..HEIGHT-3
- out_col  out  $clog2(WIDTH)  output column, 0..WIDTH-3
- frame_done  out  1  one-cycle pulse after the last output of a frame handshakes

Behaviour:
- Reset (async assert, sync release):
  - col_in=0, row_in=0
  - line buffers (2 x WIDTH bits) and window registers (3x3) cleared to 0
  - out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0
  - in_ready=1 in the first cycle after release.
- Input acceptance:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational, single output stage, no bubble under continuous flow).
- On each accept:
  - Shift the pixel into the window and line buffers.
  - Advance col_in. At WIDTH-1, col_in wraps to 0 and row_in increments.
  - At (HEIGHT-1, WIDTH-1), both counters wrap to 0; the next accepted pixel starts a new frame.
  - Line-buffer contents are never cleared between frames.
- Window validity: the window is complete when the accepted pixel's (row_in, col_in) satisfies row_in ≥2 and col_in ≥2, using values before the increment. Otherwise no output is produced.
- Compute, per channel c:
  - p = popcount over k of ~(win[k] ^ WEIGHTS[c*9+k]), range 0..9, 4 bits.
  - out_data[c] = (p ≥ THRESH[c]), unsigned compare, zero-extended to THRESH_W.
  - THRESH=0 forces 1; THRESH ≥10 forces 0.
- Latency: the output registers load on the clock edge after the accepting edge.
  - out_valid=1, out_row=row_in-2, out_col=col_in-2.
  - The window must already include the just-accepted pixel, i.e. compute from next-state window values.
- Output hold: while out_valid && !out_ready, out_data, out_row and out_col stay stable and in_ready=0.
- Output handshake: when out_valid && out_ready:
  - If a new complete window is accepted in the same cycle, load it (out_valid stays 1).
  - Otherwise out_valid falls to 0.
- frame_done asserts for exactly one cycle, on the cycle after the handshake of output (HEIGHT-3, WIDTH-3). It never asserts otherwise.
- Outputs per frame: exactly (HEIGHT-2)*(WIDTH-2), in raster order. No output for border positions (valid-mode convolution, no padding).
- Input gaps (in_valid low) only stall progress. Counters and window are unchanged.
- Reset mid-frame discards the partial frame and any pending output. The next pixel after release is (0,0).
- No combinational path from in_valid to in_ready. The only combinational output is in_ready, which depends on out_ready.

Test Plan:
- Defaults, all-ones 28x28 image, continuous valid, out_ready=1: 676 outputs, all out_data=8'hFF (p=9 ≥5). Coordinates run (0,0)..(25,25) in raster order, frame_done pulses once, one cycle after output 676, with no input stalls.
- WIDTH=5, HEIGHT=4, CH_OUT=2:
  - Channel 0: weights all 1, THRESH 9.
  - Channel 1: weights all 0, THRESH 9.
  - Image: all zeros except pixel (1,1)=1.
  - Required: 6 outputs. out_data[0]=0 for every output. out_data[1]=1 for every output whose window excludes (1,1); for outputs whose window includes (1,1), out_data[1]=0 because p=8.
- Backpressure: defaults, random in_valid, out_ready toggled ~50%. Compare against the continuous-flow reference: identical data/coordinate sequence, no drops or duplicates, outputs stable during stalls, in_ready=0 whenever out_valid && !out_ready.
- Two back-to-back 28x28 frames (checkerboard, then inverted checkerboard), no gap: 1352 outputs, two frame_done pulses. Second-frame results depend only on second-frame pixels.
- Thresholds: THRESH fields 0 and 10 on random images. The THRESH=0 channel is always 1, the THRESH=10 channel always 0.
- Assert rst after 300 accepted pixels while out_valid=1 with out_ready=0: out_valid=0 immediately (async). A full new frame then yields exactly 676 outputs, the first at (0,0).
